// File: rtl/expr_sched_pkg.sv
// Shared types for the time-multiplexed expression scheduler:
// FSM states, ALU opcodes and ALU operand-source selectors.
package expr_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    OP0,
    OP1,
    OP2,
    OP3,
    OP4,
    OP5,
    OP6,
    OP7,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    MUL,
    MOD
  } alu_op_t;

  typedef enum logic [2:0] {
    A,
    B,
    C,
    D,
    T,
    S2,
    S4,
    S5
  } alu_sel_t;

endpackage

// File: rtl/shared_alu.sv
// Single combinational ALU shared by every step of the schedule.
// All results are truncated to BW bits; x % 0 yields x.
module shared_alu
  import expr_sched_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [1:0]    op,
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  output logic [BW-1:0] r
);

  logic [2*BW-1:0] w_prod;

  assign w_prod = {{BW{1'b0}}, x} * {{BW{1'b0}}, y};

  always_comb begin
    r = '0;
    case (alu_op_t'(op))
      ADD: r = x + y;
      SUB: r = x - y;
      MUL: r = w_prod[BW-1:0];
      // guard keeps the divide-by-zero case fully defined
      MOD: r = (y == '0) ? x : (x % y);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/expr_scheduler.sv
// Evaluates s1..s6 over eight ALU steps on one operand set at a time,
// with valid/ready handshakes on the operand and result sides.
module expr_scheduler
  import expr_sched_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] c,
  input  logic [BW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] s1,
  output logic [BW-1:0] s2,
  output logic [BW-1:0] s3,
  output logic [BW-1:0] s4,
  output logic [BW-1:0] s5,
  output logic [BW-1:0] s6,
  output logic          busy
);

  state_t        r_state;
  state_t        w_state_next;
  alu_op_t       w_op;
  alu_sel_t      w_xsel;
  alu_sel_t      w_ysel;
  logic [BW-1:0] w_x;
  logic [BW-1:0] w_y;
  logic [BW-1:0] w_alu_r;

  logic [BW-1:0] r_a, r_b, r_c, r_d, r_t;
  logic [BW-1:0] r_s1, r_s2, r_s3, r_s4, r_s5, r_s6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_op         = ADD;
    w_xsel       = A;
    w_ysel       = B;
    case (r_state)
      IDLE: if (in_valid) w_state_next = OP0;
      OP0: begin w_op = ADD; w_xsel = A;  w_ysel = B;  w_state_next = OP1;  end
      OP1: begin w_op = MUL; w_xsel = A;  w_ysel = B;  w_state_next = OP2;  end
      OP2: begin w_op = MOD; w_xsel = A;  w_ysel = B;  w_state_next = OP3;  end
      OP3: begin w_op = ADD; w_xsel = T;  w_ysel = D;  w_state_next = OP4;  end
      OP4: begin w_op = ADD; w_xsel = C;  w_ysel = D;  w_state_next = OP5;  end
      OP5: begin w_op = ADD; w_xsel = T;  w_ysel = S2; w_state_next = OP6;  end
      OP6: begin w_op = SUB; w_xsel = A;  w_ysel = B;  w_state_next = OP7;  end
      OP7: begin w_op = ADD; w_xsel = S4; w_ysel = S5; w_state_next = DONE; end
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_x = '0;
    case (w_xsel)
      A:  w_x = r_a;
      B:  w_x = r_b;
      C:  w_x = r_c;
      D:  w_x = r_d;
      T:  w_x = r_t;
      S2: w_x = r_s2;
      S4: w_x = r_s4;
      S5: w_x = r_s5;
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_y = '0;
    case (w_ysel)
      A:  w_y = r_a;
      B:  w_y = r_b;
      C:  w_y = r_c;
      D:  w_y = r_d;
      T:  w_y = r_t;
      S2: w_y = r_s2;
      S4: w_y = r_s4;
      S5: w_y = r_s5;
      default: w_y = '0;
    endcase
  end

  shared_alu #(.BW(BW)) u_alu (
    .op (w_op),
    .x  (w_x),
    .y  (w_y),
    .r  (w_alu_r)
  );

  // Each OP state commits the ALU result to exactly one destination register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0; r_b  <= '0; r_c  <= '0; r_d  <= '0; r_t  <= '0;
      r_s1 <= '0; r_s2 <= '0; r_s3 <= '0;
      r_s4 <= '0; r_s5 <= '0; r_s6 <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a <= a;
        r_b <= b;
        r_c <= c;
        r_d <= d;
      end
      case (r_state)
        OP0: r_s1 <= w_alu_r;
        OP1: r_s2 <= w_alu_r;
        OP2: r_t  <= w_alu_r;
        OP3: r_s3 <= w_alu_r;
        OP4: r_t  <= w_alu_r;
        OP5: r_s4 <= w_alu_r;
        OP6: r_s5 <= w_alu_r;
        OP7: r_s6 <= w_alu_r;
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  assign s1 = r_s1;
  assign s2 = r_s2;
  assign s3 = r_s3;
  assign s4 = r_s4;
  assign s5 = r_s5;
  assign s6 = r_s6;

endmodule

// File: tb/tb_expr_scheduler.sv
// Directed, table-driven bench for expr_scheduler plus sequences for
// backpressure, asynchronous reset mid-sequence and back-to-back input.
module tb_expr_scheduler;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [BW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic          in_ready, out_valid, busy;
  logic [BW-1:0] s1, s2, s3, s4, s5, s6;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [7:0] e1, e2, e3, e4, e5, e6;
  } vec_t;

  vec_t vecs[5];

  expr_scheduler #(.BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .s4        (s4),
    .s5        (s5),
    .s6        (s6),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic chk_set(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4,
                         input logic [7:0] e5, input logic [7:0] e6);
    chk({tag, ".s1"}, 32'(s1), 32'(e1));
    chk({tag, ".s2"}, 32'(s2), 32'(e2));
    chk({tag, ".s3"}, 32'(s3), 32'(e3));
    chk({tag, ".s4"}, 32'(s4), 32'(e4));
    chk({tag, ".s5"}, 32'(s5), 32'(e5));
    chk({tag, ".s6"}, 32'(s6), 32'(e6));
  endtask

  // Caller is just after a negedge with the DUT idle; returns just after
  // the negedge following the accept edge.
  task automatic do_accept(input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] vc, input logic [7:0] vd,
                           output int acc_edge);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = va; b = vb; c = vc; d = vd;
    in_valid = 1'b1;
    @(negedge clk);
    acc_edge = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd8);
  endtask

  function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic [7:0] mc, input logic [7:0] md);
    vec_t v;
    logic [7:0] t;
    v.a = ma; v.b = mb; v.c = mc; v.d = md;
    v.e1 = ma + mb;
    v.e2 = ma * mb;
    t = (mb == 8'd0) ? ma : (ma % mb);
    v.e3 = t + md;
    v.e4 = mc + md + v.e2;
    v.e5 = ma - mb;
    v.e6 = v.e4 + v.e5;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_edge, prev_edge;
    logic [7:0] hold [6];
    vec_t pend, exp_v;
    int n_acc, n_res, busy_bad, last_acc;
    logic acc_seen;

    //                a    b    c    d    s1   s2   s3   s4   s5   s6
    vecs[0] = '{8'd7,   8'd3,   8'd2,   8'd5,  8'd10,  8'd21, 8'd6,  8'd28,  8'd4,   8'd32};
    vecs[1] = '{8'd200, 8'd100, 8'd255, 8'd1,  8'd44,  8'd32, 8'd1,  8'd32,  8'd100, 8'd132};
    vecs[2] = '{8'd9,   8'd0,   8'd1,   8'd2,  8'd9,   8'd0,  8'd11, 8'd3,   8'd9,   8'd12};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   8'd0,  8'd254, 8'd1,  8'd0,  8'd1,   8'd0,   8'd1};
    vecs[4] = '{8'd10,  8'd20,  8'd3,   8'd4,  8'd30,  8'd200, 8'd14, 8'd207, 8'd246, 8'd197};

    // reset state
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk_set("rst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // table-driven vectors, out_ready held high: one set per 10 cycles
    prev_edge = 0;
    for (int i = 0; i < 5; i++) begin
      do_accept(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, acc_edge);
      wait_done($sformatf("vec%0d", i));
      chk_set($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3,
              vecs[i].e4, vecs[i].e5, vecs[i].e6);
      chk($sformatf("vec%0d.busy_done", i), 32'(busy), 32'd1);
      chk($sformatf("vec%0d.in_ready_done", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d.idle_out_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d.idle_busy", i), 32'(busy), 32'd0);
      if (i > 0) chk($sformatf("vec%0d.spacing", i), 32'(acc_edge - prev_edge), 32'd10);
      prev_edge = acc_edge;
    end

    // backpressure: 20 cycles in DONE with noisy inputs
    out_ready = 1'b0;
    do_accept(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d, acc_edge);
    wait_done("bp");
    hold[0] = s1; hold[1] = s2; hold[2] = s3; hold[3] = s4; hold[4] = s5; hold[5] = s6;
    chk_set("bp", vecs[0].e1, vecs[0].e2, vecs[0].e3, vecs[0].e4, vecs[0].e5, vecs[0].e6);
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.held", k),
          32'({s1, s2, s3, s4} ^ {hold[0], hold[1], hold[2], hold[3]}) |
          32'({s5, s6} ^ {hold[4], hold[5]}), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release.out_valid", 32'(out_valid), 32'd0);
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);

    // asynchronous reset while in OP4
    do_accept(vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].d, acc_edge);
    repeat (4) @(negedge clk);
    chk("op4.busy", 32'(busy), 32'd1);
    chk("op4.s1_written", 32'(s1), 32'(vecs[1].e1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    chk_set("arst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_release.in_ready", 32'(in_ready), 32'd1);
    do_accept(8'd1, 8'd1, 8'd1, 8'd1, acc_edge);
    wait_done("after_rst");
    chk_set("after_rst", 8'd2, 8'd1, 8'd1, 8'd3, 8'd0, 8'd3);
    @(negedge clk);

    // back-to-back: in_valid held high with operands changing every cycle
    n_acc = 0; n_res = 0; busy_bad = 0; last_acc = 0; acc_seen = 1'b0;
    pend = model(8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        chk_set($sformatf("b2b%0d", n_res), pend.e1, pend.e2, pend.e3,
                pend.e4, pend.e5, pend.e6);
        n_res++;
      end
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      in_valid = (k < 35);
      if (in_valid && in_ready) begin
        if (acc_seen) chk($sformatf("b2b.spacing%0d", n_acc), 32'(k - last_acc), 32'd10);
        pend = model(a, b, c, d);
        last_acc = k;
        acc_seen = 1'b1;
        n_acc++;
      end else if (acc_seen && !in_ready && !busy) begin
        busy_bad++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b.accepts", 32'(n_acc), 32'd4);
    chk("b2b.results", 32'(n_res), 32'd4);
    chk("b2b.busy_bad", 32'(busy_bad), 32'd0);

    exp_v = model(8'd7, 8'd3, 8'd2, 8'd5);
    chk("model_sanity.s6", 32'(exp_v.e6), 32'(vecs[0].e6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_scheduler.md
# expr_scheduler

Time-multiplexed evaluator for the six-output datapath (s1 = a+b, s2 = a*b, s3 = a%b+d, s4 = c+d+s2, s5 = a-b, s6 = s4+s5). It evaluates all six with a single shared ALU instead of parallel operators, trading latency for area. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. One operand set is processed at a time; common subexpressions (s2 feeding s4, s4 and s5 feeding s6) are computed once and reused from registers.

## Interface
- BW, 8, operand/result width in bits (BW ≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set
- a, b, c, d  in  BW each  operands, sampled on accept
- out_valid  out  1  s1..s6 valid
- out_ready  in  1  consumer takes results
- s1..s6  out  BW each  registered results
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, OP0..OP7, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, latch a..d into operand registers and go to OP0.
- Each OPn drives the shared ALU. The result is written at the end of that cycle:
  - OP0: s1 ← a+b
  - OP1: s2 ← a*b
  - OP2: t ← a%b
  - OP3: s3 ← t+d
  - OP4: t ← c+d
  - OP5: s4 ← t+s2
  - OP6: s5 ← a−b
  - OP7: s6 ← s4+s5
- OPn advances to OPn+1 unconditionally. OP7 advances to DONE.
- DONE: out_valid=1. s1..s6 are held stable. On out_ready, go to IDLE. With no out_ready, stay in DONE indefinitely.
- Arithmetic rules:
  - All results are modulo 2^BW, truncating the low BW bits. No carries or flags.
  - The multiply keeps the low BW bits of the 2·BW product.
  - Subtraction wraps (two's complement).
  - Modulo treats operands as unsigned. a%0 is defined as a; there is no X and no error.
- t is an internal BW-bit scratch register and is not visible at the ports.
- in_ready is 0 outside IDLE. Input changes while busy are ignored.
- Reset, asserted asynchronously at any time including mid-sequence:
  - State returns to IDLE; operand registers, t and s1..s6 clear to 0.
  - out_valid=0, busy=0.
  - in_ready=1 on the first cycle after release.

## Timing
- Accept edge E (in_valid&&in_ready): state becomes OP0 after E.
- Results are written at edges E+1..E+8.
- out_valid rises after edge E+8, giving a latency of 8 cycles from accept to out_valid.
- If out_ready is high in the first DONE cycle, the state is IDLE after E+9 and the next accept is possible at E+10. Peak throughput is therefore one operand set per 10 cycles.
- s1..s6 may change only during OP states. They are stable from out_valid rising until the next accept.
- Reset values: in_ready=0 during reset (1 after release), out_valid=0, busy=0, s1..s6=0.

## Structure
- Package expr_sched_pkg holds:
  - `state_t` enum (IDLE, OP0..OP7, DONE).
  - `alu_op_t` enum (ADD, SUB, MUL, MOD).
  - `alu_sel_t` enum naming the operand sources (A, B, C, D, T, S2, S4, S5).
- Sub-module shared_alu(op, x, y) → r, BW-parameterised and purely combinational. It is the only arithmetic instance. The controller decodes state into op, x-select and y-select.
- The controller owns the FSM, operand registers, t and the result registers.

## Test plan
- BW=8; a=7, b=3, c=2, d=5; out_ready=1 → out_valid 8 cycles after accept with s1=10, s2=21, s3=6, s4=28, s5=4, s6=32; next accept at E+10.
- Wrap case: a=200, b=100, c=255, d=1 → s1=44, s2=32, s3=1, s4=32, s5=100, s6=132.
- Divide by zero: a=9, b=0, c=1, d=2 → s1=9, s2=0, s3=11, s4=3, s5=9, s6=12.
- Backpressure: hold out_ready=0 for 20 cycles in DONE, and change a..d and in_valid randomly → in_ready stays 0 and s1..s6 stay unchanged. out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously in OP4 → all outputs become 0 immediately, without waiting for a clock edge. After release in_ready=1, and a new set a=1, b=1, c=1, d=1 yields s1=2, s2=1, s3=1, s4=3, s5=0, s6=3.
- Back-to-back: hold in_valid=1 with changing operands → exactly one accept per completed sequence, each result set matches its own sampled operands, and busy is high from E through the DONE handshake.
